// File: rtl/pulse_cdc_pkg.sv
// Shared constants and helpers for the multi-channel pulse CDC.
// Edge-mode encodings and the counter-width calculation used by each channel.
package pulse_cdc_pkg;

    localparam logic [1:0] EDGE_ANY  = 2'd0;
    localparam logic [1:0] EDGE_RISE = 2'd1;
    localparam logic [1:0] EDGE_FALL = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A zero-length filter still needs a one-bit counter so the port widths stay legal
    function automatic int cnt_width(input int filter_cnt);
        return (clog2(filter_cnt + 1) < 1) ? 1 : clog2(filter_cnt + 1);
    endfunction

endpackage

// File: rtl/pulse_cdc_ch.sv
// One event channel: synchroniser chain, stability filter, edge qualifier,
// sticky pending flag and overrun flag.
module pulse_cdc_ch
    import pulse_cdc_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int FILTER_CNT = 0,
    parameter int EDGE_MODE  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    input  logic ch_en,
    input  logic evt_ack,
    input  logic ovr_clr,
    output logic sync_level,
    output logic sync_pulse,
    output logic evt_pend,
    output logic overrun
);

    localparam int            CW      = cnt_width(FILTER_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CNT);
    localparam logic [1:0]    MODE    = (EDGE_MODE == 1) ? EDGE_RISE :
                                        (EDGE_MODE == 2) ? EDGE_FALL : EDGE_ANY;

    (* syn_preserve = 1 *) logic [NUM_STAGES-1:0] sff;
    logic [CW-1:0] cnt;
    logic          sync_in;
    logic          chg;
    logic          edge_ok;
    logic          qual;

    // Pure flop-to-flop chain so the metastability window sees no logic
    always_ff @(posedge clk) begin
        if (reset) begin
            sff <= '0;
        end else begin
            sff <= {sff[NUM_STAGES-2:0], data_in};
        end
    end

    assign sync_in = sff[NUM_STAGES-1];
    assign chg     = (sync_in != sync_level) && (cnt == CNT_MAX);

    always_comb begin
        edge_ok = 1'b1;
        case (MODE)
            EDGE_RISE: edge_ok = sync_in;
            EDGE_FALL: edge_ok = ~sync_in;
            default:   edge_ok = 1'b1;
        endcase
    end

    assign qual = ch_en & chg & edge_ok;

    // A level is accepted only after it has disagreed with the filtered level FILTER_CNT+1 times in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_level <= 1'b0;
            cnt        <= '0;
        end else if (sync_in == sync_level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            sync_level <= sync_in;
            cnt        <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Setting wins over clearing for both sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_pulse <= 1'b0;
            evt_pend   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync_pulse <= qual;
            evt_pend   <= sync_pulse | (evt_pend & ~evt_ack);
            overrun    <= (sync_pulse & evt_pend & ~evt_ack) | (overrun & ~ovr_clr);
        end
    end

endmodule

// File: rtl/pulse_cdc_multi.sv
// Destination-side multi-channel event synchroniser: NUM_CH independent
// pulse_cdc_ch instances with no interaction between channels.
module pulse_cdc_multi
    import pulse_cdc_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int NUM_STAGES = 2,
    parameter int FILTER_CNT = 0,
    parameter int EDGE_MODE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] data_in,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] evt_ack,
    input  logic [NUM_CH-1:0] ovr_clr,
    output logic [NUM_CH-1:0] sync_level,
    output logic [NUM_CH-1:0] sync_pulse,
    output logic [NUM_CH-1:0] evt_pend,
    output logic [NUM_CH-1:0] overrun
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_cdc_ch #(
            .NUM_STAGES (NUM_STAGES),
            .FILTER_CNT (FILTER_CNT),
            .EDGE_MODE  (EDGE_MODE)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .data_in    (data_in[i]),
            .ch_en      (ch_en[i]),
            .evt_ack    (evt_ack[i]),
            .ovr_clr    (ovr_clr[i]),
            .sync_level (sync_level[i]),
            .sync_pulse (sync_pulse[i]),
            .evt_pend   (evt_pend[i]),
            .overrun    (overrun[i])
        );
    end

endmodule

// File: tb/tb_pulse_cdc_multi.sv
// Bench for pulse_cdc_multi: four configurations share one stimulus stream
// (F=0 any, F=3 any, F=0 rise, F=0 fall) and are checked against a window-based model.
module tb_pulse_cdc_multi;

    localparam int NCH  = 4;
    localparam int NDUT = 4;
    localparam int NST  = 2;
    localparam int FLT  [NDUT] = '{0, 3, 0, 0};
    localparam int MODE [NDUT] = '{0, 0, 1, 2};

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] data_in, ch_en, evt_ack, ovr_clr;
    logic [NCH-1:0] lvl  [NDUT];
    logic [NCH-1:0] pls  [NDUT];
    logic [NCH-1:0] pend [NDUT];
    logic [NCH-1:0] ovr  [NDUT];

    logic [NCH-1:0] m_lvl  [NDUT];
    logic [NCH-1:0] m_pls  [NDUT];
    logic [NCH-1:0] m_pend [NDUT];
    logic [NCH-1:0] m_ovr  [NDUT];
    int             m_edges [NDUT][NCH];
    logic [NCH-1:0] hist [$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pulse_cdc_multi #(.NUM_CH(NCH), .NUM_STAGES(NST), .FILTER_CNT(0), .EDGE_MODE(0)) dut_any (
        .clk(clk), .reset(reset), .data_in(data_in), .ch_en(ch_en), .evt_ack(evt_ack),
        .ovr_clr(ovr_clr), .sync_level(lvl[0]), .sync_pulse(pls[0]), .evt_pend(pend[0]), .overrun(ovr[0]));
    pulse_cdc_multi #(.NUM_CH(NCH), .NUM_STAGES(NST), .FILTER_CNT(3), .EDGE_MODE(0)) dut_flt (
        .clk(clk), .reset(reset), .data_in(data_in), .ch_en(ch_en), .evt_ack(evt_ack),
        .ovr_clr(ovr_clr), .sync_level(lvl[1]), .sync_pulse(pls[1]), .evt_pend(pend[1]), .overrun(ovr[1]));
    pulse_cdc_multi #(.NUM_CH(NCH), .NUM_STAGES(NST), .FILTER_CNT(0), .EDGE_MODE(1)) dut_rise (
        .clk(clk), .reset(reset), .data_in(data_in), .ch_en(ch_en), .evt_ack(evt_ack),
        .ovr_clr(ovr_clr), .sync_level(lvl[2]), .sync_pulse(pls[2]), .evt_pend(pend[2]), .overrun(ovr[2]));
    pulse_cdc_multi #(.NUM_CH(NCH), .NUM_STAGES(NST), .FILTER_CNT(0), .EDGE_MODE(2)) dut_fall (
        .clk(clk), .reset(reset), .data_in(data_in), .ch_en(ch_en), .evt_ack(evt_ack),
        .ovr_clr(ovr_clr), .sync_level(lvl[3]), .sync_pulse(pls[3]), .evt_pend(pend[3]), .overrun(ovr[3]));

    // Model: the filtered level flips once the input seen N edges late has held the
    // opposite value for F+1 consecutive edges; flags follow the set/ack/clear rules.
    task automatic model_edge();
        logic want, stable, newl, q, p_old;
        if (reset) begin
            for (int d = 0; d < NDUT; d++) begin
                m_lvl[d] = '0; m_pls[d] = '0; m_pend[d] = '0; m_ovr[d] = '0;
                for (int c = 0; c < NCH; c++) m_edges[d][c] = 0;
            end
            hist.delete();
            for (int i = 0; i < 10; i++) hist.push_front('0);
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    want   = ~m_lvl[d][c];
                    stable = 1'b1;
                    for (int j = 0; j <= FLT[d]; j++) begin
                        if (hist[NST-1+j][c] != want) stable = 1'b0;
                    end
                    newl = stable ? want : m_lvl[d][c];
                    q = ch_en[c] & stable &
                        ((MODE[d] == 1) ? newl : (MODE[d] == 2) ? ~newl : 1'b1);
                    p_old = m_pend[d][c];
                    m_pend[d][c] = m_pls[d][c] | (p_old & ~evt_ack[c]);
                    m_ovr[d][c]  = (m_pls[d][c] & p_old & ~evt_ack[c]) | (m_ovr[d][c] & ~ovr_clr[c]);
                    m_pls[d][c]  = q;
                    m_lvl[d][c]  = newl;
                    if (q) m_edges[d][c]++;
                end
            end
            hist.push_front(data_in);
            if (hist.size() > 12) void'(hist.pop_back());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        data_in = '0;
        ch_en   = '1;
        evt_ack = '0;
        ovr_clr = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if ({lvl[d], pls[d], pend[d], ovr[d]} !== 16'h0) begin
                n_err++;
                $display("[TB] FAIL reset_state dut%0d: got %h expected 0000", d, {lvl[d], pls[d], pend[d], ovr[d]});
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        data_in[0] = 1'b1;
        tick();
        tick();
        n_vec++;
        if (lvl[0][0] !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_lvl_early: got %b expected 0", lvl[0][0]);
        end
        tick();
        n_vec++;
        if ({lvl[0][0], pls[0][0], pend[0][0]} !== 3'b110) begin
            n_err++;
            $display("[TB] FAIL basic_lvl_pulse: got %b expected 110", {lvl[0][0], pls[0][0], pend[0][0]});
        end
        tick();
        n_vec++;
        if ({lvl[0][0], pls[0][0], pend[0][0]} !== 3'b101) begin
            n_err++;
            $display("[TB] FAIL basic_pend_set: got %b expected 101", {lvl[0][0], pls[0][0], pend[0][0]});
        end
    endtask

    task automatic test_filter();
        logic seen;
        do_reset();
        data_in[0] = 1'b1;
        repeat (3) tick();
        data_in[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= lvl[1][0] | pls[1][0];
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL filter_glitch: got change=%b expected 0", seen);
        end
        data_in[0] = 1'b1;
        repeat (4) tick();
        data_in[0] = 1'b0;
        tick();
        n_vec++;
        if (lvl[1][0] !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL filter_early: got %b expected 0", lvl[1][0]);
        end
        tick();
        n_vec++;
        if ({lvl[1][0], pls[1][0]} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL filter_accept: got %b expected 11", {lvl[1][0], pls[1][0]});
        end
    endtask

    task automatic test_edge_modes();
        int cnt [NDUT];
        logic lvl_at [NDUT];
        do_reset();
        for (int d = 0; d < NDUT; d++) begin
            cnt[d] = 0;
            lvl_at[d] = 1'bx;
        end
        for (int i = 0; i < 14; i++) begin
            if (i == 0) data_in[1] = 1'b1;
            if (i == 7) data_in[1] = 1'b0;
            tick();
            for (int d = 0; d < NDUT; d++) begin
                if (pls[d][1]) begin
                    cnt[d]++;
                    lvl_at[d] = lvl[d][1];
                end
            end
        end
        n_vec++;
        if (cnt[0] !== 2 || cnt[1] !== 2) begin
            n_err++;
            $display("[TB] FAIL mode_any_count: got %0d/%0d expected 2/2", cnt[0], cnt[1]);
        end
        n_vec++;
        if (cnt[2] !== 1 || lvl_at[2] !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL mode_rise: got count %0d level %b expected 1 and 1", cnt[2], lvl_at[2]);
        end
        n_vec++;
        if (cnt[3] !== 1 || lvl_at[3] !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL mode_fall: got count %0d level %b expected 1 and 0", cnt[3], lvl_at[3]);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        data_in[2] = 1'b1;
        repeat (4) tick();
        data_in[2] = 1'b0;
        repeat (4) tick();
        n_vec++;
        if ({pend[0][2], ovr[0][2]} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL overrun_set: got pend/ovr %b expected 11", {pend[0][2], ovr[0][2]});
        end
        ovr_clr[2] = 1'b1;
        tick();
        ovr_clr[2] = 1'b0;
        n_vec++;
        if ({pend[0][2], ovr[0][2]} !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL overrun_clr: got pend/ovr %b expected 10", {pend[0][2], ovr[0][2]});
        end
        data_in[2] = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (pls[0][2] !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL ack_pulse: got %b expected 1", pls[0][2]);
        end
        evt_ack[2] = 1'b1;
        tick();
        n_vec++;
        if ({pend[0][2], ovr[0][2]} !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL ack_vs_set: got pend/ovr %b expected 10", {pend[0][2], ovr[0][2]});
        end
        tick();
        evt_ack[2] = 1'b0;
        n_vec++;
        if (pend[0][2] !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL ack_clear: got %b expected 0", pend[0][2]);
        end
    endtask

    task automatic test_ch_en();
        logic seen;
        do_reset();
        ch_en[3] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in[3] = ~data_in[3];
            for (int t = 0; t < 3; t++) begin
                tick();
                seen |= pls[0][3] | pend[0][3] | ovr[0][3];
            end
            n_vec++;
            if (lvl[0][3] !== data_in[3]) begin
                n_err++;
                $display("[TB] FAIL chen_level_%0d: got %b expected %b", i, lvl[0][3], data_in[3]);
            end
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL chen_no_event: got %b expected 0", seen);
        end
        ch_en = '1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_in = '1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if ({lvl[d], pls[d], pend[d], ovr[d]} !== 16'h0) begin
                n_err++;
                $display("[TB] FAIL reset_mid dut%0d: got %h expected 0000", d, {lvl[d], pls[d], pend[d], ovr[d]});
            end
        end
        tick();
        tick();
        n_vec++;
        if (lvl[0] !== 4'h0) begin
            n_err++;
            $display("[TB] FAIL reset_hold_early: got %h expected 0", lvl[0]);
        end
        tick();
        n_vec++;
        if ({lvl[0], pls[0]} !== 8'hff) begin
            n_err++;
            $display("[TB] FAIL reset_hold_rise: got %h expected ff", {lvl[0], pls[0]});
        end
    endtask

    task automatic test_random();
        int d_cnt [NDUT][NCH];
        do_reset();
        for (int d = 0; d < NDUT; d++)
            for (int c = 0; c < NCH; c++) d_cnt[d][c] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) == 0) data_in[c] = ~data_in[c];
            end
            if (cyc % 100 == 50) ch_en = 4'($urandom) | 4'($urandom);
            evt_ack = 4'($urandom) & 4'($urandom);
            ovr_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
            tick();
            for (int d = 0; d < NDUT; d++) begin
                for (int c = 0; c < NCH; c++) d_cnt[d][c] += int'(pls[d][c]);
                n_vec++;
                if ({lvl[d], pls[d], pend[d], ovr[d]} !== {m_lvl[d], m_pls[d], m_pend[d], m_ovr[d]}) begin
                    n_err++;
                    $display("[TB] FAIL random_cyc%0d_dut%0d: got lvl/pls/pend/ovr %h expected %h", cyc, d,
                             {lvl[d], pls[d], pend[d], ovr[d]}, {m_lvl[d], m_pls[d], m_pend[d], m_ovr[d]});
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NCH; c++) begin
                n_vec++;
                if (d_cnt[d][c] !== m_edges[d][c]) begin
                    n_err++;
                    $display("[TB] FAIL random_pulse_count dut%0d ch%0d: got %0d expected %0d",
                             d, c, d_cnt[d][c], m_edges[d][c]);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        data_in = '0;
        ch_en   = '1;
        evt_ack = '0;
        ovr_clr = '0;
        test_reset();
        test_basic();
        test_filter();
        test_edge_modes();
        test_overrun();
        test_ch_en();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
